// File: rtl/stack_register_unit_if.sv
// Op request/response bundle between the sequencer (master) and the stack register unit (slave).
interface stack_register_unit_if;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [31:0] op_data;
   logic        done;
   logic        err;
   logic [31:0] pop_data;
   logic [31:0] esp;
   logic [31:0] ebp;
   logic [31:0] stack;

   modport master (
      output op_valid, op_code, op_data,
      input  op_ready, done, err, pop_data, esp, ebp, stack
   );

   modport slave (
      input  op_valid, op_code, op_data,
      output op_ready, done, err, pop_data, esp, ebp, stack
   );
endinterface

// File: rtl/stack_register_unit.sv
// ESP/EBP registers plus a downward-growing word stack RAM driven by push/pop/frame ops.
// Optional range checking of pushes, pops and ESP loads: define STACK_BOUNDS_CHECK_EN.
module stack_register_unit #(
   parameter int          DEPTH     = 64,
   parameter int          ADDR_W    = 6,
   parameter logic [31:0] STACK_TOP = 32'h0000_0100
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   stack_register_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_POP_RD, S_RESP} state_t;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_E2B  = 3'd3;
   localparam logic [2:0] OP_B2E  = 3'd4;
   localparam logic [2:0] OP_LDSP = 3'd5;
   localparam logic [2:0] OP_LDBP = 3'd6;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_esp, w_esp_nxt;
   logic [31:0] r_ebp, w_ebp_nxt;
   logic [31:0] r_pop_data, w_pop_nxt;
   logic        r_err, w_err_nxt;
   logic [31:0] r_rd_data;
   logic [31:0] r_mem [DEPTH];

   logic              w_accept, w_we;
   logic [31:0]       w_esp_dec, w_aligned;
   logic [ADDR_W-1:0] w_widx, w_ridx;
   logic              w_full, w_empty, w_ld_ok, w_ebp_ok;

   assign w_accept  = bus.op_valid && (r_state == S_IDLE);
   assign w_esp_dec = r_esp - 32'd4;
   assign w_aligned = {bus.op_data[31:2], 2'b00};
   assign w_widx    = w_esp_dec[ADDR_W+1:2];
   assign w_ridx    = r_esp[ADDR_W+1:2];

`ifdef STACK_BOUNDS_CHECK_EN
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   localparam logic [31:0] BASE = STACK_TOP - SPAN;

   // Offset from BASE keeps the range test a single unsigned compare, even when BASE is 0.
   function automatic logic in_range(input logic [31:0] v);
      return (v - BASE) <= SPAN;
   endfunction

   assign w_full   = (r_esp == BASE);
   assign w_empty  = (r_esp == STACK_TOP);
   assign w_ld_ok  = in_range(w_aligned);
   assign w_ebp_ok = in_range(r_ebp);
`else
   assign w_full   = 1'b0;
   assign w_empty  = 1'b0;
   assign w_ld_ok  = 1'b1;
   assign w_ebp_ok = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_esp_nxt   = r_esp;
      w_ebp_nxt   = r_ebp;
      w_pop_nxt   = r_pop_data;
      w_err_nxt   = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_RESP;
               case (bus.op_code)
                  OP_NOP: ;
                  OP_PUSH: begin
                     if (w_full) w_err_nxt = 1'b1;
                     else begin
                        w_we      = 1'b1;
                        w_esp_nxt = w_esp_dec;
                     end
                  end
                  OP_POP: begin
                     if (w_empty) w_err_nxt = 1'b1;
                     else         w_state_nxt = S_POP_RD;
                  end
                  OP_E2B: w_ebp_nxt = r_esp;
                  OP_B2E: begin
                     if (w_ebp_ok) w_esp_nxt = r_ebp;
                     else          w_err_nxt = 1'b1;
                  end
                  OP_LDSP: begin
                     if (w_ld_ok) w_esp_nxt = w_aligned;
                     else         w_err_nxt = 1'b1;
                  end
                  OP_LDBP: w_ebp_nxt = w_aligned;
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end
         S_POP_RD: begin
            w_pop_nxt   = r_rd_data;
            w_esp_nxt   = r_esp + 32'd4;
            w_state_nxt = S_RESP;
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_esp      <= STACK_TOP;
         r_ebp      <= STACK_TOP;
         r_pop_data <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_esp      <= w_esp_nxt;
         r_ebp      <= w_ebp_nxt;
         r_pop_data <= w_pop_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // RAM is never cleared; the read captured in the accept cycle is consumed in POP_RD.
   always_ff @(posedge i_clock) begin
      if (w_we) r_mem[w_widx] <= bus.op_data;
      r_rd_data <= r_mem[w_ridx];
   end

   assign bus.op_ready = (r_state == S_IDLE);
   assign bus.done     = (r_state == S_RESP);
   assign bus.err      = r_err;
   assign bus.pop_data = r_pop_data;
   assign bus.esp      = r_esp;
   assign bus.ebp      = r_ebp;
   assign bus.stack    = (r_esp == STACK_TOP) ? 32'h0 : r_mem[w_ridx];

endmodule

// File: tb/tb_stack_register_unit.sv
// Scoreboard bench for stack_register_unit: reference model queues expected responses at accept.
module tb_stack_register_unit;

   localparam logic [31:0] TOP = 32'h0000_0100;

   logic i_clock, i_reset_n;
   stack_register_unit_if bus();

   stack_register_unit dut (.i_clock(i_clock), .i_reset_n(i_reset_n), .bus(bus.slave));

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   typedef struct {
      logic        err;
      logic [31:0] pop;
      logic        pop_known;
      logic [31:0] esp;
      logic [31:0] ebp;
      logic [31:0] stk;
      logic        stk_known;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   logic [31:0] m_esp, m_ebp, m_pop;
   logic        m_pop_known;
   logic [31:0] m_mem [64];
   logic        m_vld [64];

   always @(posedge i_clock) cyc <= cyc + 1;

   // Response monitor: every done pulse must match the oldest queued expectation.
   always @(negedge i_clock) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: done=1 with no op outstanding at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if ((cyc - e.acc) != e.lat) begin
               n_fail++; $display("FAIL latency: got %0d need %0d", cyc - e.acc, e.lat);
            end
            n_tests++;
            if (bus.err !== e.err) begin
               n_fail++; $display("FAIL err: got %b need %b", bus.err, e.err);
            end
            n_tests++;
            if (bus.esp !== e.esp) begin
               n_fail++; $display("FAIL esp: got %h need %h", bus.esp, e.esp);
            end
            n_tests++;
            if (bus.ebp !== e.ebp) begin
               n_fail++; $display("FAIL ebp: got %h need %h", bus.ebp, e.ebp);
            end
            n_tests++;
            if (bus.op_ready !== 1'b0) begin
               n_fail++; $display("FAIL ready_in_resp: got %b need 0", bus.op_ready);
            end
            if (e.pop_known) begin
               n_tests++;
               if (bus.pop_data !== e.pop) begin
                  n_fail++; $display("FAIL pop_data: got %h need %h", bus.pop_data, e.pop);
               end
            end
            if (e.stk_known) begin
               n_tests++;
               if (bus.stack !== e.stk) begin
                  n_fail++; $display("FAIL stack: got %h need %h", bus.stack, e.stk);
               end
            end
         end
      end
   end

   function automatic logic [5:0] idx(input logic [31:0] a);
      return a[7:2];
   endfunction

   function automatic logic in_rng(input logic [31:0] v);
      return v <= TOP;
   endfunction

   task automatic model_reset();
      m_esp = TOP; m_ebp = TOP; m_pop = 32'h0; m_pop_known = 1'b1;
   endtask

   task automatic apply_reset();
      i_reset_n = 1'b0;
      bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_data = 32'h0;
      repeat (2) @(negedge i_clock);
      i_reset_n = 1'b1;
      model_reset();
      sb.delete();
   endtask

   task automatic run_op(input logic [2:0] code, input logic [31:0] data);
      exp_t e;
      logic [31:0] v;
      int k;
      @(negedge i_clock);
      k = 0;
      while (bus.op_ready !== 1'b1 && k < 10) begin @(negedge i_clock); k++; end
      v = {data[31:2], 2'b00};
      e.err = 1'b0; e.lat = 1;
      case (code)
         3'd1: begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (m_esp == 32'h0) e.err = 1'b1; else
`endif
            begin
               m_esp = m_esp - 32'd4;
               m_mem[idx(m_esp)] = data; m_vld[idx(m_esp)] = 1'b1;
            end
         end
         3'd2: begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (m_esp == TOP) e.err = 1'b1; else
`endif
            begin
               e.lat = 2;
               m_pop = m_mem[idx(m_esp)]; m_pop_known = m_vld[idx(m_esp)];
               m_esp = m_esp + 32'd4;
            end
         end
         3'd3: m_ebp = m_esp;
         3'd4: begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (!in_rng(m_ebp)) e.err = 1'b1; else
`endif
            m_esp = m_ebp;
         end
         3'd5: begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (!in_rng(v)) e.err = 1'b1; else
`endif
            m_esp = v;
         end
         3'd6: m_ebp = v;
         3'd7: e.err = 1'b1;
         default: ;
      endcase
      e.esp = m_esp; e.ebp = m_ebp; e.pop = m_pop; e.pop_known = m_pop_known;
      if (m_esp == TOP) begin e.stk = 32'h0; e.stk_known = 1'b1; end
      else begin e.stk = m_mem[idx(m_esp)]; e.stk_known = m_vld[idx(m_esp)]; end
      e.acc = cyc;
      sb.push_back(e);
      bus.op_valid = 1'b1; bus.op_code = code; bus.op_data = data;
      @(posedge i_clock);
      #1;
      bus.op_valid = 1'b0; bus.op_code = 3'($urandom); bus.op_data = $urandom;
      k = 0;
      do begin @(negedge i_clock); #1; k++; end while (sb.size() != 0 && k < 8);
      if (sb.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: op %0d no done after %0d cycles", code, k);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_tests++; if (bus.esp !== TOP) begin n_fail++; $display("FAIL rst_esp: got %h need %h", bus.esp, TOP); end
      n_tests++; if (bus.ebp !== TOP) begin n_fail++; $display("FAIL rst_ebp: got %h need %h", bus.ebp, TOP); end
      n_tests++; if (bus.pop_data !== 32'h0) begin n_fail++; $display("FAIL rst_pop: got %h need 0", bus.pop_data); end
      n_tests++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", bus.op_ready); end
      n_tests++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err: got %b%b need 00", bus.done, bus.err); end
      n_tests++; if (bus.stack !== 32'h0) begin n_fail++; $display("FAIL rst_stack: got %h need 0", bus.stack); end
   endtask

   task automatic test_reset_mid_pop();
      run_op(3'd1, 32'h5555_AAAA);
      @(negedge i_clock);
      bus.op_valid = 1'b1; bus.op_code = 3'd2;
      @(posedge i_clock);
      #1 bus.op_valid = 1'b0;
      i_reset_n = 1'b0;
      #1;
      n_tests++; if (bus.esp !== TOP || bus.ebp !== TOP) begin n_fail++; $display("FAIL midpop_ptrs: got %h/%h need %h", bus.esp, bus.ebp, TOP); end
      repeat (2) @(negedge i_clock);
      i_reset_n = 1'b1;
      model_reset();
      repeat (3) @(negedge i_clock);
      n_tests++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL midpop_ready: got %b need 1", bus.op_ready); end
      n_tests++; if (bus.pop_data !== 32'h0) begin n_fail++; $display("FAIL midpop_pop: got %h need 0", bus.pop_data); end
      n_tests++; if (bus.esp !== TOP) begin n_fail++; $display("FAIL midpop_esp: got %h need %h", bus.esp, TOP); end
   endtask

   task automatic test_push();
      run_op(3'd1, 32'hDEAD_BEEF);
      n_tests++; if (bus.esp !== 32'hFC || bus.stack !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL push1: got %h/%h need 000000fc/deadbeef", bus.esp, bus.stack); end
      run_op(3'd1, 32'h0000_1234);
      n_tests++; if (bus.esp !== 32'hF8 || bus.stack !== 32'h1234) begin n_fail++; $display("FAIL push2: got %h/%h need 000000f8/00001234", bus.esp, bus.stack); end
   endtask

   task automatic test_pop();
      run_op(3'd2, 32'h0);
      n_tests++; if (bus.pop_data !== 32'h1234) begin n_fail++; $display("FAIL pop1: got %h need 00001234", bus.pop_data); end
      run_op(3'd2, 32'h0);
      n_tests++; if (bus.pop_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pop2: got %h need deadbeef", bus.pop_data); end
      n_tests++; if (bus.esp !== TOP || bus.stack !== 32'h0) begin n_fail++; $display("FAIL pop_empty: got %h/%h need 00000100/0", bus.esp, bus.stack); end
   endtask

   task automatic test_frame();
      run_op(3'd1, 32'hA0A0_0001);
      run_op(3'd1, 32'hB0B0_0002);
      run_op(3'd1, 32'hC0C0_0003);
      run_op(3'd3, 32'h0);
      n_tests++; if (bus.ebp !== 32'hF4) begin n_fail++; $display("FAIL frame_ebp: got %h need 000000f4", bus.ebp); end
      run_op(3'd1, 32'hD0D0_0004);
      run_op(3'd4, 32'h0);
      n_tests++; if (bus.esp !== 32'hF4 || bus.stack !== 32'hC0C0_0003) begin n_fail++; $display("FAIL frame_esp: got %h/%h need 000000f4/c0c00003", bus.esp, bus.stack); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op((i % 2) ? 3'd0 : 3'd6, 32'h40 + 32'(i * 8) + 32'd3);
         n_tests++;
         if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b need 0", bus.op_ready); end
         @(negedge i_clock);
         n_tests++;
         if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b need 1", bus.op_ready); end
      end
      n_tests++; if (bus.ebp !== 32'h50) begin n_fail++; $display("FAIL b2b_ebp: got %h need 00000050", bus.ebp); end
   endtask

`ifdef STACK_BOUNDS_CHECK_EN
   task automatic test_bounds();
      apply_reset();
      run_op(3'd2, 32'h0);
      n_tests++; if (bus.esp !== TOP) begin n_fail++; $display("FAIL bnd_pop_esp: got %h need 00000100", bus.esp); end
      for (int i = 0; i < 64; i++) run_op(3'd1, 32'h1000 + 32'(i));
      run_op(3'd1, 32'hFFFF_0000);
      n_tests++; if (bus.esp !== 32'h0 || bus.stack !== 32'h103F) begin n_fail++; $display("FAIL bnd_full: got %h/%h need 0/0000103f", bus.esp, bus.stack); end
      run_op(3'd5, 32'h200);
      run_op(3'd5, 32'hFB);
      run_op(3'd6, 32'h300);
      run_op(3'd4, 32'h0);
      n_tests++; if (bus.esp !== 32'hF8) begin n_fail++; $display("FAIL bnd_b2e: got %h need 000000f8", bus.esp); end
   endtask
`else
   task automatic test_nobounds();
      apply_reset();
      run_op(3'd2, 32'h0);
      n_tests++; if (bus.esp !== 32'h104 || bus.err !== 1'b0) begin n_fail++; $display("FAIL nb_pop_empty: got %h err %b need 00000104 0", bus.esp, bus.err); end
      run_op(3'd5, 32'hF3);
      n_tests++; if (bus.esp !== 32'hF0) begin n_fail++; $display("FAIL nb_ld_esp: got %h need 000000f0", bus.esp); end
      run_op(3'd7, 32'h1);
      run_op(3'd5, 32'h0);
      run_op(3'd1, 32'h7777_0001);
      n_tests++; if (bus.esp !== 32'hFFFF_FFFC || bus.stack !== 32'h7777_0001) begin n_fail++; $display("FAIL nb_wrap: got %h/%h need fffffffc/77770001", bus.esp, bus.stack); end
      run_op(3'd2, 32'h0);
      n_tests++; if (bus.esp !== 32'h0 || bus.pop_data !== 32'h7777_0001) begin n_fail++; $display("FAIL nb_wrap_pop: got %h/%h need 0/77770001", bus.esp, bus.pop_data); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) begin m_mem[i] = 32'h0; m_vld[i] = 1'b0; end
      model_reset();
      test_reset();
      test_reset_mid_pop();
      test_push();
      test_pop();
      test_frame();
      test_back_to_back();
`ifdef STACK_BOUNDS_CHECK_EN
      test_bounds();
`else
      test_nobounds();
`endif
      repeat (3) @(negedge i_clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
